lsu_mem_arbiter: RTL and testbench
==================================

# lsu_mem_arbiter

Two-requester arbiter and sequencer for the single-port 256 x 32 data memory used by load/store execution. Requesters present base + offset, read/write, and write data. The block computes the word address, bounds-checks it, and runs the memory access as a small FSM. It then returns read data and a completion pulse to the winner. It sits between the load/store datapath (requester 0) and a secondary master such as the debug/program loader (requester 1) on one side, and the data memory macro on the other.

## Interface
- ADDR_W, 8, memory word-address width (depth = 2^ADDR_W)
- DATA_W, 32, data width

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- r0_valid / r1_valid  in  1  request pending; held until matching ready pulse
- r0_we / r1_we  in  1  1 = store, 0 = load
- r0_base / r1_base  in  32  base operand (register read value)
- r0_offset / r1_offset  in  32  offset operand (immediate)
- r0_wdata / r1_wdata  in  DATA_W  store data
- r0_ready / r1_ready  out  1  one-cycle acceptance pulse; requester may change inputs after it
- r0_done / r1_done  out  1  one-cycle completion pulse
- rdata  out  DATA_W  load result; valid with done, held until the next load completes
- addr_err  out  1  pulses with done when the address is out of range
- busy  out  1  high in every state except IDLE
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe (only with mem_en)
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a mem_en read

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample r0_valid/r1_valid. If either is set, pick a winner, latch its we/wdata, latch sum = base + offset (32-bit, modulo 2^32), then go to ISSUE. With no requests, stay in IDLE.
- Address: mem_addr = sum[ADDR_W-1:0]. Out of range iff sum[31:ADDR_W] != 0.
- ISSUE: assert winner's ready for exactly this cycle.
  - In range: mem_en=1, mem_we=latched we, mem_addr/mem_wdata driven. Store goes to DONE; load goes to WAIT.
  - Out of range: mem_en=0, go to DONE with the error flag set.
- WAIT: capture mem_rdata into rdata, then go to DONE.
- DONE: pulse winner's done (plus addr_err if flagged). Update the arbitration pointer, then go to IDLE.
- Loser's valid stays high and is not acknowledged. It is re-arbitrated at the next IDLE.
- rdata changes only on a successful load. Stores and errors leave it unchanged.
- mem_we is never high without mem_en. mem_* is 0 outside ISSUE.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, all ready/done/addr_err/busy/mem_en/mem_we = 0, mem_addr=0, mem_wdata=0, rdata=0, arbitration pointer = "last grant r1" (so r0 wins first).
- Load: valid seen in IDLE at cycle T; ready + mem_en at T+1; rdata capture at T+2; done at T+3; IDLE at T+4. Minimum 4 cycles per load.
- Store: ready + mem_en/mem_we at T+1; done at T+2; IDLE at T+3.
- Out-of-range: ready at T+1; done + addr_err at T+2; no memory access.
- Simultaneous valid in IDLE: resolved per the Configuration section.
- valid deasserted before being sampled in IDLE is never seen. valid deasserted after ready has no effect.
- Reset asserted mid-operation: immediate return to IDLE with reset values. The in-flight access is abandoned, with no done pulse. A store already strobed in ISSUE may have been written.

## Configuration
- LSU_ARB_ROUND_ROBIN_EN defined: on a tie, the requester not granted last wins. The pointer updates in DONE, including for errored requests.
- Undefined: fixed priority, r0 always wins ties, and the pointer register is not built. r1 can starve while r0 keeps valid high.

## Test plan
- Reset, then r0 store base=0x10, offset=4, wdata=0xDEADBEEF -> r0_ready at T+1 with mem_en=mem_we=1, mem_addr=0x14; r0_done at T+2; rdata stays 0.
- r0 load base=0x10, offset=4 after the above -> mem_addr=0x14, mem_we=0 at T+1; rdata=0xDEADBEEF with r0_done at T+3; addr_err=0.
- r1 load base=0xFFFFFFFC, offset=0x8 -> sum wraps to 0x4, in range, mem_addr=0x04. Separately, base=0x100, offset=0 -> no mem_en, addr_err and r1_done at T+2.
- r0 and r1 both held valid for 4 requests -> with the macro, grant order r0, r1, r0, r1. Without it, r0 is served for all 4 while r1 is never acknowledged.
- Reset pulsed at the WAIT cycle of a load -> all outputs 0 next cycle, no done pulse. A new request after reset completes normally with 4-cycle latency.

Source files
------------

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: two-requester arbiter and sequencer for a single-port
// 2^ADDR_W x DATA_W data memory. It computes base + offset, bounds-checks the
// word address, performs the access and returns rdata plus a done pulse.
// Optional feature: define LSU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// otherwise r0 has fixed priority.
module lsu_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [31:0]       r0_base,
  input  logic [31:0]       r0_offset,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic              r0_done,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [31:0]       r1_base,
  input  logic [31:0]       r1_offset,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic              r1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              addr_err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, state_d;

  // Per-transaction latches: winner (1 = r1), store flag, out-of-range flag.
  logic win_q, win_d;
  logic we_q, we_d;
  logic err_q, err_d;

  // Next-cycle values of the registered outputs.
  logic              r0_ready_d, r1_ready_d;
  logic              r0_done_d, r1_done_d;
  logic              addr_err_d, busy_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] rdata_d;

  // Winner selection and address computation for the request sampled in IDLE.
  logic              pick_r1;
  logic [31:0]       sel_base, sel_offset, sum;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic              out_of_range;

`ifdef LSU_ARB_ROUND_ROBIN_EN
  logic last_r1, last_r1_d;

  // Tie goes to whichever requester was not granted last.
  always_comb begin
    pick_r1 = r1_valid && (!r0_valid || !last_r1);
  end
`else
  // Fixed priority: r1 only wins when r0 is not requesting.
  always_comb begin
    pick_r1 = r1_valid && !r0_valid;
  end
`endif

  // Mux the winner's operands and form the word address and range flag.
  always_comb begin
    sel_base     = pick_r1 ? r1_base   : r0_base;
    sel_offset   = pick_r1 ? r1_offset : r0_offset;
    sel_we       = pick_r1 ? r1_we     : r0_we;
    sel_wdata    = pick_r1 ? r1_wdata  : r0_wdata;
    sum          = sel_base + sel_offset;
    out_of_range = |sum[31:ADDR_W];
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // and registered so each pulse lines up with the state it belongs to.
  always_comb begin
    state_d     = state;
    win_d       = win_q;
    we_d        = we_q;
    err_d       = err_q;
    r0_ready_d  = 1'b0;
    r1_ready_d  = 1'b0;
    r0_done_d   = 1'b0;
    r1_done_d   = 1'b0;
    addr_err_d  = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    rdata_d     = rdata;
`ifdef LSU_ARB_ROUND_ROBIN_EN
    last_r1_d   = last_r1;
`endif
    case (state)
      IDLE: begin
        if (r0_valid || r1_valid) begin
          state_d    = ISSUE;
          win_d      = pick_r1;
          we_d       = sel_we;
          err_d      = out_of_range;
          r0_ready_d = !pick_r1;
          r1_ready_d = pick_r1;
          if (!out_of_range) begin
            mem_en_d    = 1'b1;
            mem_we_d    = sel_we;
            mem_addr_d  = sum[ADDR_W-1:0];
            mem_wdata_d = sel_wdata;
          end
        end
      end
      ISSUE: begin
        if (err_q || we_q) begin
          state_d    = DONE;
          r0_done_d  = !win_q;
          r1_done_d  = win_q;
          addr_err_d = err_q;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d   = DONE;
        rdata_d   = mem_rdata;
        r0_done_d = !win_q;
        r1_done_d = win_q;
      end
      DONE: begin
        state_d = IDLE;
`ifdef LSU_ARB_ROUND_ROBIN_EN
        last_r1_d = win_q;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, transaction latches and all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      r0_ready  <= 1'b0;
      r1_ready  <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      addr_err  <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state     <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      err_q     <= err_d;
      r0_ready  <= r0_ready_d;
      r1_ready  <= r1_ready_d;
      r0_done   <= r0_done_d;
      r1_done   <= r1_done_d;
      addr_err  <= addr_err_d;
      busy      <= busy_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      rdata     <= rdata_d;
    end
  end

`ifdef LSU_ARB_ROUND_ROBIN_EN
  // Arbitration pointer; reset as if r1 was granted last so r0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_r1 <= 1'b1;
    else     last_r1 <= last_r1_d;
  end
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Scoreboard bench for lsu_mem_arbiter: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares on ready/done pulses.
module tb_lsu_mem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_valid, r0_we, r0_ready, r0_done;
  logic [31:0]       r0_base, r0_offset;
  logic [DATA_W-1:0] r0_wdata;
  logic              r1_valid, r1_we, r1_ready, r1_done;
  logic [31:0]       r1_base, r1_offset;
  logic [DATA_W-1:0] r1_wdata;
  logic [DATA_W-1:0] rdata;
  logic              addr_err, busy, mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  lsu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_base(r0_base), .r0_offset(r0_offset),
    .r0_wdata(r0_wdata), .r0_ready(r0_ready), .r0_done(r0_done),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_base(r1_base), .r1_offset(r1_offset),
    .r1_wdata(r1_wdata), .r1_ready(r1_ready), .r1_done(r1_done),
    .rdata(rdata), .addr_err(addr_err), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Synchronous single-port memory: read data one cycle after mem_en.
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    int          id;
    bit          we;
    bit          err;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          rcyc;
  } rdy_t;

  typedef struct {
    int          id;
    bit          err;
    logic [31:0] rdata;
    int          lat;
  } done_t;

  rdy_t  rdy_q[$];
  done_t done_q[$];
  rdy_t  re;
  done_t de;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_rdata = '0;
  int last_rdy_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Push the expected ready and (optionally) done responses for one request.
  task automatic expect_req(input int id, input bit we, input logic [31:0] base,
                            input logic [31:0] off, input logic [31:0] wdata,
                            input logic [31:0] exp_ld, input int rcyc, input bit want_done);
    logic [31:0] s;
    bit err;
    rdy_t r;
    done_t d;
    s   = base + off;
    err = (s[31:8] != 24'h0);
    r.id = id; r.we = we; r.err = err; r.addr = s[7:0]; r.wdata = wdata; r.rcyc = rcyc;
    rdy_q.push_back(r);
    if (want_done) begin
      if (!we && !err) model_rdata = exp_ld;
      d.id = id; d.err = err; d.rdata = model_rdata; d.lat = (!we && !err) ? 2 : 1;
      done_q.push_back(d);
    end
  endtask

  task automatic drive(input int id, input bit we, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wdata);
    if (id == 0) begin
      r0_valid = 1'b1; r0_we = we; r0_base = base; r0_offset = off; r0_wdata = wdata;
    end else begin
      r1_valid = 1'b1; r1_we = we; r1_base = base; r1_offset = off; r1_wdata = wdata;
    end
  endtask

  task automatic wait_ready(input int id);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if ((id == 0) ? r0_ready : r1_ready) seen = 1'b1;
    end
    if (id == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: r%0d ready not seen, expected within 10 cycles", id);
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 12 && !idle; i++) begin
      @(posedge clk); #1;
      if (!busy) idle = 1'b1;
    end
    if (!idle) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: busy still 1, expected 0 within 12 cycles");
    end
  endtask

  task automatic do_req(input int id, input bit we, input logic [31:0] base,
                        input logic [31:0] off, input logic [31:0] wdata,
                        input logic [31:0] exp_ld);
    @(posedge clk); #1;
    expect_req(id, we, base, off, wdata, exp_ld, cyc + 1, 1'b1);
    drive(id, we, base, off, wdata);
    wait_ready(id);
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {r0_ready, r1_ready}, 0);
    check({tag, "_done"}, {r0_done, r1_done}, 0);
    check({tag, "_err_busy"}, {addr_err, busy}, 0);
    check({tag, "_mem_ctl"}, {mem_en, mem_we}, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_rdata"}, rdata, 0);
  endtask

  // Monitor: compare every ready/done pulse against the scoreboard queues.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (r0_ready && r1_ready) begin
        n_tests++; n_fail++;
        $display("FAIL dual_ready: both readies high, expected one");
      end
      if (r0_ready || r1_ready) begin
        if (rdy_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_ready: r0=%0b r1=%0b, expected none", r0_ready, r1_ready);
        end else begin
          re = rdy_q.pop_front();
          check("ready_id", r1_ready, re.id);
          check("mem_en", mem_en, !re.err);
          check("mem_we", mem_we, re.we && !re.err);
          if (!re.err) check("mem_addr", mem_addr, re.addr);
          if (re.we && !re.err) check("mem_wdata", mem_wdata, re.wdata);
          if (re.rcyc >= 0) check("ready_cycle", cyc, re.rcyc);
          last_rdy_cyc = cyc;
        end
      end else begin
        check("mem_quiet", {mem_en, mem_we}, 0);
      end
      if (r0_done || r1_done) begin
        if (done_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: r0=%0b r1=%0b, expected none", r0_done, r1_done);
        end else begin
          de = done_q.pop_front();
          check("done_id", {r1_done, r0_done}, (de.id == 1) ? 2 : 1);
          check("addr_err", addr_err, de.err);
          check("rdata", rdata, de.rdata);
          check("done_latency", cyc - last_rdy_cyc, de.lat);
        end
      end else if (addr_err) begin
        n_tests++; n_fail++;
        $display("FAIL stray_addr_err: addr_err=1 without done, expected 0");
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, i0, i1;
    bit fin;
    rst = 1'b1;
    r0_valid = 0; r0_we = 0; r0_base = 0; r0_offset = 0; r0_wdata = 0;
    r1_valid = 0; r1_we = 0; r1_base = 0; r1_offset = 0; r1_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Basic store then load through r0.
    do_req(0, 1, 32'h10, 32'h4, 32'hDEADBEEF, 32'h0);
    do_req(0, 0, 32'h10, 32'h4, 32'h0, 32'hDEADBEEF);
    // r1: prime word 4, then load it through a wrapping sum.
    do_req(1, 1, 32'h0, 32'h4, 32'h55AA1234, 32'h0);
    do_req(1, 0, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h55AA1234);
    // Out-of-range store (must not write word 0) and out-of-range load.
    do_req(0, 1, 32'h80, 32'h80, 32'h12345678, 32'h0);
    do_req(1, 0, 32'h100, 32'h0, 32'h0, 32'h0);

    // Both requesters held valid; r1 was granted last.
`ifdef LSU_ARB_ROUND_ROBIN_EN
    n0 = 2;
`else
    n0 = 4;
`endif
    @(posedge clk); #1;
`ifdef LSU_ARB_ROUND_ROBIN_EN
    expect_req(0, 1, 32'h20, 0, 32'h1000, 0, cyc + 1, 1'b1);
    expect_req(1, 0, 32'h20, 0, 0, 32'h1000, -1, 1'b1);
    expect_req(0, 1, 32'h21, 0, 32'h1001, 0, -1, 1'b1);
    expect_req(1, 0, 32'h21, 0, 0, 32'h1001, -1, 1'b1);
`else
    expect_req(0, 1, 32'h20, 0, 32'h1000, 0, cyc + 1, 1'b1);
    expect_req(0, 1, 32'h21, 0, 32'h1001, 0, -1, 1'b1);
    expect_req(0, 1, 32'h22, 0, 32'h1002, 0, -1, 1'b1);
    expect_req(0, 1, 32'h23, 0, 32'h1003, 0, -1, 1'b1);
    expect_req(1, 0, 32'h20, 0, 0, 32'h1000, -1, 1'b1);
    expect_req(1, 0, 32'h21, 0, 0, 32'h1001, -1, 1'b1);
`endif
    drive(0, 1, 32'h20, 0, 32'h1000);
    drive(1, 0, 32'h20, 0, 0);
    i0 = 0; i1 = 0; fin = 1'b0;
    for (int c = 0; c < 80 && !fin; c++) begin
      @(posedge clk); #1;
      if (r0_ready) begin
        i0++;
        if (i0 < n0) drive(0, 1, 32'h20 + i0, 0, 32'h1000 + i0);
        else r0_valid = 1'b0;
      end
      if (r1_ready) begin
        i1++;
        if (i1 < 2) drive(1, 0, 32'h20 + i1, 0, 0);
        else r1_valid = 1'b0;
      end
      if (i0 == n0 && i1 == 2) fin = 1'b1;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    if (!fin) begin
      n_tests++; n_fail++;
      $display("FAIL arb_timeout: grants r0=%0d r1=%0d, expected %0d and 2", i0, i1, n0);
    end
    wait_idle();

    // Reset during the WAIT cycle of a load: no done, everything cleared.
    @(posedge clk); #1;
    expect_req(0, 0, 32'h10, 32'h4, 0, 0, cyc + 1, 1'b0);
    drive(0, 0, 32'h10, 32'h4, 0);
    wait_ready(0);
    @(posedge clk); #1;
    check("busy_in_wait", busy, 1);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    model_rdata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(0, 0, 32'h10, 32'h4, 32'h0, 32'hDEADBEEF);
    // Word 0 must be untouched by the errored store.
    do_req(0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    check("rdy_q_drained", rdy_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
